// File: rtl/cv32e40s_obi_trans_ctrl_if.sv
// -----------------------------------------------------------------------------
// cv32e40s_obi_trans_ctrl_if
//
// Bundles the core-side transfer handshake and the OBI address/response
// signals seen by cv32e40s_obi_trans_ctrl.
//
//   master modport : the transfer controller (drives obi_* requests, the core
//                    handshake ready, the outstanding count and error flags)
//   slave modport  : the environment (core + OBI slave) driving the inputs
//
// Signals
//   trans_valid_i / trans_ready_o   core-side transfer request / accept
//   trans_addr_i, trans_wdata_i     32-bit address and write data
//   trans_we_i, trans_be_i          write enable, 4-bit byte enables
//   trans_integrity_i               PMA integrity attribute of the transfer
//   obi_req_o, obi_reqpar_o         OBI request and its (inverted) parity
//   obi_addr_o, obi_wdata_o         OBI address and write data
//   obi_we_o, obi_be_o              OBI write enable, byte enables
//   obi_integrity_o                 integrity attribute of the address phase
//   obi_gnt_i, obi_gntpar_i         grant and grant parity
//   obi_rvalid_i                    response valid
//   gntpar_err_o                    grant parity error
//   outstnd_cnt_o                   granted transfers still awaiting rvalid
//   protocol_err_o                  rvalid with nothing outstanding
// -----------------------------------------------------------------------------
interface cv32e40s_obi_trans_ctrl_if;

   // Core-side transfer handshake
   logic        trans_valid_i;
   logic        trans_ready_o;
   logic [31:0] trans_addr_i;
   logic [31:0] trans_wdata_i;
   logic        trans_we_i;
   logic [3:0]  trans_be_i;
   logic        trans_integrity_i;

   // OBI address phase
   logic        obi_req_o;
   logic        obi_reqpar_o;
   logic [31:0] obi_addr_o;
   logic [31:0] obi_wdata_o;
   logic        obi_we_o;
   logic [3:0]  obi_be_o;
   logic        obi_integrity_o;
   logic        obi_gnt_i;
   logic        obi_gntpar_i;

   // OBI response phase
   logic        obi_rvalid_i;

   // Status
   logic        gntpar_err_o;
   logic [2:0]  outstnd_cnt_o;
   logic        protocol_err_o;

   modport master (
      input  trans_valid_i,
      output trans_ready_o,
      input  trans_addr_i,
      input  trans_wdata_i,
      input  trans_we_i,
      input  trans_be_i,
      input  trans_integrity_i,
      output obi_req_o,
      output obi_reqpar_o,
      output obi_addr_o,
      output obi_wdata_o,
      output obi_we_o,
      output obi_be_o,
      output obi_integrity_o,
      input  obi_gnt_i,
      input  obi_gntpar_i,
      input  obi_rvalid_i,
      output gntpar_err_o,
      output outstnd_cnt_o,
      output protocol_err_o
   );

   modport slave (
      output trans_valid_i,
      input  trans_ready_o,
      output trans_addr_i,
      output trans_wdata_i,
      output trans_we_i,
      output trans_be_i,
      output trans_integrity_i,
      input  obi_req_o,
      input  obi_reqpar_o,
      input  obi_addr_o,
      input  obi_wdata_o,
      input  obi_we_o,
      input  obi_be_o,
      input  obi_integrity_o,
      output obi_gnt_i,
      output obi_gntpar_i,
      output obi_rvalid_i,
      input  gntpar_err_o,
      input  outstnd_cnt_o,
      input  protocol_err_o
   );

endinterface : cv32e40s_obi_trans_ctrl_if

// File: rtl/cv32e40s_obi_trans_ctrl.sv
// -----------------------------------------------------------------------------
// cv32e40s_obi_trans_ctrl
//
// OBI address-phase controller. A core transfer is forwarded to the OBI bus
// combinationally (zero added latency when granted in the request cycle). If
// the slave does not grant immediately, the transfer is captured into a
// holding register and replayed from there until granted, so the address
// phase stays stable whatever the core does with its inputs meanwhile.
// A counter tracks granted transfers still awaiting rvalid and blocks new
// requests once MAX_OUTSTANDING are in flight.
//
// Parameters
//   MAX_OUTSTANDING  maximum granted transfers awaiting rvalid (1..7)
//
// Ports
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    cv32e40s_obi_trans_ctrl_if.master (core handshake, OBI signals,
//          outstanding count and error flags)
// -----------------------------------------------------------------------------
module cv32e40s_obi_trans_ctrl #(
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   cv32e40s_obi_trans_ctrl_if.master         bus
);

   localparam logic [2:0] CNT_MAX = 3'(MAX_OUTSTANDING);

   typedef enum logic {
      TRANSPARENT = 1'b0,
      REGISTERED  = 1'b1
   } state_e;

   // Everything that makes up one address phase
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      logic [3:0]  be;
      logic        integrity;
   } addr_phase_t;

   state_e      state_q;
   addr_phase_t hold_q;
   logic [2:0]  cnt_q;

   addr_phase_t trans_phase;
   addr_phase_t obi_phase;
   logic        full;
   logic        obi_req;
   logic        count_up;
   logic        count_down;
   logic [2:0]  cnt_n;

   assign trans_phase = '{
      addr:      bus.trans_addr_i,
      wdata:     bus.trans_wdata_i,
      we:        bus.trans_we_i,
      be:        bus.trans_be_i,
      integrity: bus.trans_integrity_i
   };

   // A returning rvalid frees a slot in the same cycle, so full is released
   // early and a new request can go out alongside the response.
   assign full = (cnt_q == CNT_MAX) && !bus.obi_rvalid_i;

   // -----------------------------------------------------------------------
   // Address-phase output selection
   // -----------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before any branch so that no path
      // leaves it unassigned, which would otherwise infer a latch.
      obi_req          = 1'b0;
      obi_phase        = trans_phase;
      bus.trans_ready_o = 1'b0;

      unique case (state_q)
         TRANSPARENT: begin
            obi_req           = bus.trans_valid_i && !full;
            obi_phase         = trans_phase;
            bus.trans_ready_o = obi_req && bus.obi_gnt_i && rst_n;
         end
         REGISTERED: begin
            // Core is not acknowledged on the grant cycle; it re-presents
            // its next transfer from the following cycle.
            obi_req           = 1'b1;
            obi_phase         = hold_q;
            bus.trans_ready_o = 1'b0;
         end
         default: begin
            obi_req           = 1'b0;
            obi_phase         = trans_phase;
            bus.trans_ready_o = 1'b0;
         end
      endcase

      // Reset drops the request immediately, independent of the clock
      obi_req = obi_req && rst_n;
   end

   assign bus.obi_req_o       = obi_req;
   assign bus.obi_reqpar_o    = !obi_req;
   assign bus.obi_addr_o      = obi_phase.addr;
   assign bus.obi_wdata_o     = obi_phase.wdata;
   assign bus.obi_we_o        = obi_phase.we;
   assign bus.obi_be_o        = obi_phase.be;
   assign bus.obi_integrity_o = obi_phase.integrity;

   // Grant parity is the inverse of grant; equality means a parity fault
   assign bus.gntpar_err_o = obi_req && (bus.obi_gnt_i == bus.obi_gntpar_i);

   // -----------------------------------------------------------------------
   // Outstanding-transfer counter
   // -----------------------------------------------------------------------
   assign count_up   = obi_req && bus.obi_gnt_i;
   assign count_down = bus.obi_rvalid_i && (cnt_q != 3'd0);

   always_comb begin
      unique case ({count_up, count_down})
         2'b10:   cnt_n = cnt_q + 3'd1;
         2'b01:   cnt_n = cnt_q - 3'd1;
         default: cnt_n = cnt_q;
      endcase
   end

   assign bus.outstnd_cnt_o  = cnt_q;
   assign bus.protocol_err_o = bus.obi_rvalid_i && (cnt_q == 3'd0) && rst_n;

   // -----------------------------------------------------------------------
   // State, holding register and counter
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= TRANSPARENT;
         cnt_q   <= 3'd0;
         // NOTE: the holding register is reset too; it is visible on the bus
         // as soon as the FSM enters REGISTERED, so it must never hold X.
         hold_q  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values of its inputs.
         cnt_q <= cnt_n;
         unique case (state_q)
            TRANSPARENT: begin
               if (obi_req && !bus.obi_gnt_i) begin
                  state_q <= REGISTERED;
                  hold_q  <= trans_phase;
               end
            end
            REGISTERED: begin
               if (bus.obi_gnt_i) begin
                  state_q <= TRANSPARENT;
               end
            end
            default: state_q <= TRANSPARENT;
         endcase
      end
   end

endmodule : cv32e40s_obi_trans_ctrl

// File: doc/cv32e40s_obi_trans_ctrl.md
CV32E40S_OBI_TRANS_CTRL -- requirements
Module: cv32e40s_obi_trans_ctrl

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 2, meaning the maximum number of granted transfers awaiting rvalid (range 1..7).
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 trans_valid_i  input  1  core-side transfer request.
REQ-005 trans_ready_o  output  1  core-side transfer accepted this cycle.
REQ-006 trans_addr_i, trans_wdata_i  input  32 each  transfer address and write data.
REQ-007 trans_we_i  input  1  write enable.
REQ-008 trans_be_i  input  4  byte enables.
REQ-009 trans_integrity_i  input  1  PMA integrity attribute for the transfer.
REQ-010 obi_req_o  output  1  OBI address-phase request.
REQ-011 obi_reqpar_o  output  1  OBI request parity, always equal to !obi_req_o.
REQ-012 obi_addr_o, obi_wdata_o  output  32 each  OBI address and write data.
REQ-013 obi_we_o  output  1  OBI write enable.
REQ-014 obi_be_o  output  4  OBI byte enables.
REQ-015 obi_integrity_o  output  1  integrity attribute of the current address phase, fed to the downstream integrity FIFO.
REQ-016 obi_gnt_i, obi_gntpar_i  input  1 each  grant and grant parity.
REQ-017 obi_rvalid_i  input  1  response valid.
REQ-018 gntpar_err_o  output  1  grant parity error, combinational: obi_gnt_i == obi_gntpar_i, qualified by obi_req_o.
REQ-019 outstnd_cnt_o  output  3  number of granted transfers without rvalid.
REQ-020 protocol_err_o  output  1  rvalid received with zero outstanding transfers.

Function
REQ-021 The FSM SHALL have two states, TRANSPARENT and REGISTERED, with reset state TRANSPARENT.
REQ-022 TRANSPARENT: obi_req_o SHALL be trans_valid_i && !full, and the OBI address fields SHALL pass through from the trans_* inputs combinationally.
REQ-023 full SHALL be (outstnd_cnt_q == MAX_OUTSTANDING) && !obi_rvalid_i.
REQ-024 trans_ready_o SHALL be obi_req_o && obi_gnt_i in TRANSPARENT, and 0 in REGISTERED.
REQ-025 TRANSPARENT -> REGISTERED SHALL occur when obi_req_o && !obi_gnt_i; on that edge the addr/wdata/we/be/integrity values SHALL be captured into a holding register.
REQ-026 REGISTERED: obi_req_o SHALL be 1 and the OBI fields SHALL be driven from the holding register, so the address phase stays stable until grant regardless of trans_* inputs.
REQ-027 REGISTERED -> TRANSPARENT SHALL occur on obi_gnt_i; the held transfer counts as granted on that edge.
REQ-028 In REGISTERED, trans_ready_o SHALL stay 0 on the grant cycle; the core re-presents its next request from the following cycle.
REQ-029 Counter update: count_up = obi_req_o && obi_gnt_i; count_down = obi_rvalid_i && cnt != 0.
  - up only: +1.
  - down only: -1.
  - both: hold.
REQ-030 The counter SHALL never exceed MAX_OUTSTANDING and never underflow; an rvalid arriving at cnt == 0 SHALL leave cnt at 0 and assert protocol_err_o that cycle.
REQ-031 Grant while cnt == MAX_OUTSTANDING and no rvalid is impossible, because obi_req_o is 0; in REGISTERED, req was raised before cnt reached full, so this case SHALL not be reachable.
REQ-032 Zero-latency rule: a request and its grant in the same cycle SHALL complete in that cycle with no register stage added.

Reset
REQ-033 On rst_n low, the FSM SHALL go to TRANSPARENT and the counter and holding register SHALL clear to 0.
REQ-034 During reset, obi_req_o=0, obi_reqpar_o=1, trans_ready_o=0, gntpar_err_o=0, protocol_err_o=0, outstnd_cnt_o=0.
REQ-035 Reset asserted mid-address-phase SHALL drop obi_req_o immediately (asynchronously), and no transfer SHALL be counted.

Verification
REQ-036 Transfer granted in the request cycle: trans_valid_i=1, addr=0x100, gnt=1 -> obi_req_o=1, obi_addr_o=0x100, trans_ready_o=1 in the same cycle; outstnd_cnt_o=1 next cycle.
REQ-037 Waited grant with changing inputs:
  - stimulus: addr=0x200 with gnt=0 for 3 cycles, trans_addr_i changed to 0x300 after the first cycle.
  - response: obi_addr_o stays 0x200 until gnt; trans_ready_o stays 0 throughout; state returns to TRANSPARENT after gnt.
REQ-038 Full stall: MAX_OUTSTANDING=2, two grants without rvalid -> obi_req_o=0 while trans_valid_i=1; rvalid then arrives -> obi_req_o=1 that cycle, and a grant in that cycle keeps cnt at 2.
REQ-039 Spurious response: rvalid with cnt=0 -> protocol_err_o=1 for one cycle, cnt stays 0.
REQ-040 Grant parity: obi_req_o=1, gnt=1, gntpar=1 -> gntpar_err_o=1; gnt=1, gntpar=0 -> gntpar_err_o=0; obi_reqpar_o == !obi_req_o in every cycle.
REQ-041 Reset in REGISTERED: rst_n low while waiting for gnt -> obi_req_o=0 and cnt=0 immediately; after reset release, the first request behaves as in REQ-036.
